// File: rtl/song_sequencer.sv
// Song sequencer: walks a song ROM, holds each note for its beat count with a
// trailing silent gap, and loops at the end-of-song marker.
module song_sequencer #(
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       pause,
  input  logic       song_sel,
  input  logic [9:0] rom_data,
  output logic [8:0] rom_addr,
  output logic [9:0] fullnote,
  output logic       note_start,
  output logic       song_end,
  output logic       playing
);

  localparam logic [31:0] BEAT     = 32'(BEAT_CYCLES);
  localparam logic [31:0] GAP      = 32'(GAP_CYCLES);
  localparam logic [9:0]  END_MARK = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY,
    S_GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  index_q, index_d;
  logic [31:0] cnt_q, cnt_d;
  logic [5:0]  note_q, note_d;
  logic        sel_q, sel_d;
  logic        first_q, first_d;

  logic        sel_change;
  logic [31:0] dur_beats;
  logic [31:0] play_load;

  assign sel_change = (song_sel != sel_q);
  // 16 beats at the default beat length is 400M cycles, well inside 32 bits.
  assign dur_beats  = 32'(rom_data[9:6]) + 32'd1;
  assign play_load  = dur_beats * BEAT - GAP - 32'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d    = state_q;
    index_d    = index_q;
    cnt_d      = cnt_q;
    note_d     = note_q;
    first_d    = first_q;
    sel_d      = song_sel;
    note_start = 1'b0;
    song_end   = 1'b0;

    if (sel_change) begin
      state_d = S_FETCH;
      index_d = '0;
      cnt_d   = '0;
      note_d  = '0;
      first_d = 1'b0;
    end else if (!pause) begin
      unique case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          if (rom_data == END_MARK) begin
            song_end = 1'b1;
            index_d  = '0;
            state_d  = S_FETCH;
          end else begin
            note_d  = rom_data[5:0];
            cnt_d   = play_load;
            first_d = 1'b1;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          // first_q survives a pause so the pulse is neither lost nor repeated.
          note_start = first_q;
          first_d    = 1'b0;
          if (cnt_q == '0) begin
            note_d  = '0;
            cnt_d   = GAP - 32'd1;
            state_d = S_GAP;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            index_d = index_q + 8'd1;
            state_d = S_FETCH;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      index_q <= '0;
      cnt_q   <= '0;
      note_q  <= '0;
      sel_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      sel_q   <= sel_d;
      first_q <= first_d;
    end
  end

  assign rom_addr = {sel_q, index_q};
  assign fullnote = {4'b0, note_q};
  assign playing  = ((state_q == S_PLAY) || (state_q == S_GAP)) && !pause;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with BEAT_CYCLES = 10, GAP_CYCLES = 2.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       pause = 1'b0;
  logic       song_sel = 1'b0;
  logic [9:0] rom_data;
  logic [8:0] rom_addr;
  logic [9:0] fullnote;
  logic       note_start;
  logic       song_end;
  logic       playing;

  logic [9:0] rom [0:511];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address is valid one cycle later.
  always @(posedge clk) rom_data <= rom[rom_addr];

  song_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .pause      (pause),
    .song_sel   (song_sel),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .fullnote   (fullnote),
    .note_start (note_start),
    .song_end   (song_end),
    .playing    (playing)
  );

  task automatic load_song1();
    for (int i = 0; i < 512; i++) rom[i] = 10'h3FF;
    rom[0] = 10'h045;  // dur 1, note 5
    rom[1] = 10'h000;  // dur 0, rest
    rom[2] = 10'h3FF;
  endtask

  task automatic reset_release();
    RESET = 1'b1;
    repeat (2) @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    pause = 1'b0;
    song_sel = 1'b0;
    load_song1();
    RESET = 1'b1;
    #1;
    checks++;
    if ({rom_addr, fullnote, note_start, song_end, playing} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {rom_addr, fullnote, note_start, song_end, playing});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({rom_addr, fullnote, note_start, song_end, playing} !== 22'd0) begin
      errors++;
      $display("FAIL reset_held: got %h expected 0", {rom_addr, fullnote, note_start, song_end, playing});
    end
  endtask

  task automatic test_song1();
    logic [9:0] fn [1:39];
    logic [8:0] ad [1:39];
    logic       ns [1:39];
    logic       se [1:39];
    logic       pl [1:39];
    int n5, last5, ns_cnt, ns1, ns2, se_cnt, se_at;
    load_song1();
    song_sel = 1'b0;
    pause = 1'b0;
    reset_release();
    for (int k = 1; k <= 39; k++) begin
      @(negedge clk);
      fn[k] = fullnote; ad[k] = rom_addr; ns[k] = note_start; se[k] = song_end; pl[k] = playing;
    end
    n5 = 0; last5 = 0; ns_cnt = 0; ns1 = 0; ns2 = 0; se_cnt = 0; se_at = 0;
    for (int k = 1; k <= 36; k++) begin
      if (fn[k] == 10'd5) begin n5++; last5 = k; end
      if (ns[k]) begin
        ns_cnt++;
        if (ns_cnt == 1) ns1 = k;
        if (ns_cnt == 2) ns2 = k;
      end
      if (se[k]) begin se_cnt++; se_at = k; end
    end
    checks++;
    if (ad[1] !== 9'h000 || pl[1] !== 1'b0) begin
      errors++;
      $display("FAIL song1_fetch0: got addr %h playing %b expected 000 0", ad[1], pl[1]);
    end
    checks++;
    if (ns1 !== 3 || fn[3] !== 10'd5) begin
      errors++;
      $display("FAIL song1_first_start: got cycle %0d note %0d expected 3 5", ns1, fn[3]);
    end
    checks++;
    if (n5 !== 18 || last5 !== 20) begin
      errors++;
      $display("FAIL song1_note5_dwell: got %0d cycles ending %0d expected 18 ending 20", n5, last5);
    end
    checks++;
    if (fn[21] !== 10'd0 || pl[21] !== 1'b1 || fn[22] !== 10'd0 || pl[22] !== 1'b1) begin
      errors++;
      $display("FAIL song1_gap: got note %0d/%0d playing %b/%b expected 0/0 1/1", fn[21], fn[22], pl[21], pl[22]);
    end
    checks++;
    if (ad[23] !== 9'h001) begin
      errors++;
      $display("FAIL song1_fetch1: got %h expected 001", ad[23]);
    end
    checks++;
    if (ns_cnt !== 2 || ns2 !== 25 || fn[25] !== 10'd0) begin
      errors++;
      $display("FAIL song1_rest_start: got %0d starts, second at %0d note %0d expected 2 25 0", ns_cnt, ns2, fn[25]);
    end
    checks++;
    if (se_cnt !== 1 || se_at !== 36) begin
      errors++;
      $display("FAIL song1_song_end: got %0d pulses at %0d expected 1 at 36", se_cnt, se_at);
    end
    checks++;
    if (ad[37] !== 9'h000 || se[37] !== 1'b0) begin
      errors++;
      $display("FAIL song1_loop_addr: got %h end %b expected 000 0", ad[37], se[37]);
    end
    checks++;
    if (ns[39] !== 1'b1 || fn[39] !== 10'd5) begin
      errors++;
      $display("FAIL song1_loop_note: got start %b note %0d expected 1 5", ns[39], fn[39]);
    end
  endtask

  task automatic test_pause();
    int act, held, ns_cnt, ns_paused, bad_held;
    load_song1();
    song_sel = 1'b0;
    pause = 1'b0;
    reset_release();
    act = 0; held = 0; ns_cnt = 0; ns_paused = 0; bad_held = 0;
    for (int k = 1; k <= 29; k++) begin
      @(negedge clk);
      if (fullnote == 10'd5 && playing) act++;
      if (pause && fullnote == 10'd5 && !playing) held++;
      if (pause && fullnote != 10'd5) bad_held++;
      if (note_start) ns_cnt++;
      if (note_start && pause) ns_paused++;
      if (k == 7) pause = 1'b1;
      if (k == 14) pause = 1'b0;
    end
    checks++;
    if (held !== 7 || bad_held !== 0) begin
      errors++;
      $display("FAIL pause_hold: got %0d held, %0d wrong expected 7 0", held, bad_held);
    end
    checks++;
    if (act !== 18) begin
      errors++;
      $display("FAIL pause_dwell: got %0d active cycles expected 18", act);
    end
    checks++;
    if (ns_cnt !== 1 || ns_paused !== 0) begin
      errors++;
      $display("FAIL pause_starts: got %0d starts, %0d while paused expected 1 0", ns_cnt, ns_paused);
    end
  endtask

  task automatic test_song_change();
    logic [9:0] fn [1:8];
    logic [8:0] ad [1:8];
    logic       ns [1:8];
    int se_cnt;
    load_song1();
    rom[256] = 10'h083;  // dur 2, note 3
    song_sel = 1'b0;
    pause = 1'b0;
    reset_release();
    se_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      fn[k] = fullnote; ad[k] = rom_addr; ns[k] = note_start;
      if (song_end) se_cnt++;
      if (k == 5) song_sel = 1'b1;
    end
    checks++;
    if (fn[5] !== 10'd5 || fn[6] !== 10'd0) begin
      errors++;
      $display("FAIL change_silence: got %0d then %0d expected 5 then 0", fn[5], fn[6]);
    end
    checks++;
    if (ad[6] !== 9'h100 || ns[6] !== 1'b0) begin
      errors++;
      $display("FAIL change_fetch: got addr %h start %b expected 100 0", ad[6], ns[6]);
    end
    checks++;
    if (fn[8] !== 10'd3 || ns[8] !== 1'b1 || se_cnt !== 0) begin
      errors++;
      $display("FAIL change_song2: got note %0d start %b ends %0d expected 3 1 0", fn[8], ns[8], se_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] ad13, ad_last, ad_wrap;
    int ns_cnt, se_cnt;
    load_song1();
    for (int i = 256; i < 512; i++) rom[i] = 10'h001;  // dur 0, note 1
    song_sel = 1'b1;
    pause = 1'b0;
    reset_release();
    ns_cnt = 0; se_cnt = 0; ad13 = '0; ad_last = '0; ad_wrap = '1;
    for (int k = 1; k <= 3074; k++) begin
      @(negedge clk);
      if (note_start) ns_cnt++;
      if (song_end) se_cnt++;
      if (k == 13) ad13 = rom_addr;
      if (k == 3061) ad_last = rom_addr;
      if (k == 3073) ad_wrap = rom_addr;
    end
    checks++;
    if (ad13 !== 9'h101 || ad_last !== 9'h1FF) begin
      errors++;
      $display("FAIL wrap_progress: got %h %h expected 101 1ff", ad13, ad_last);
    end
    checks++;
    if (ad_wrap !== 9'h100) begin
      errors++;
      $display("FAIL wrap_addr: got %h expected 100", ad_wrap);
    end
    checks++;
    if (ns_cnt !== 256 || se_cnt !== 0) begin
      errors++;
      $display("FAIL wrap_counts: got %0d starts %0d ends expected 256 0", ns_cnt, se_cnt);
    end
    song_sel = 1'b0;
  endtask

  task automatic test_reset_gap();
    logic ns [1:3];
    logic [9:0] fn3;
    load_song1();
    song_sel = 1'b0;
    pause = 1'b0;
    reset_release();
    repeat (33) @(negedge clk);
    checks++;
    if (playing !== 1'b1 || rom_addr !== 9'h001) begin
      errors++;
      $display("FAIL rgap_precondition: got playing %b addr %h expected 1 001", playing, rom_addr);
    end
    @(posedge clk);
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({rom_addr, fullnote, note_start, song_end, playing} !== 22'd0) begin
      errors++;
      $display("FAIL rgap_immediate: got %h expected 0", {rom_addr, fullnote, note_start, song_end, playing});
    end
    @(negedge clk);
    RESET = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      ns[k] = note_start;
    end
    fn3 = fullnote;
    checks++;
    if ({ns[1], ns[2], ns[3]} !== 3'b001 || fn3 !== 10'd5) begin
      errors++;
      $display("FAIL rgap_restart: got starts %b note %0d expected 001 5", {ns[1], ns[2], ns[3]}, fn3);
    end
    repeat (6) @(negedge clk);
    #1 RESET = 1'b1;
    #1;
    checks++;
    if (fullnote !== 10'd0) begin
      errors++;
      $display("FAIL rmid_silence: got %0d expected 0", fullnote);
    end
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic test_long();
    int n9, gapc, ns1, ns2, ns_cnt;
    load_song1();
    rom[0] = 10'h3C9;  // dur 15, note 9
    song_sel = 1'b0;
    pause = 1'b0;
    reset_release();
    n9 = 0; gapc = 0; ns1 = 0; ns2 = 0; ns_cnt = 0;
    for (int k = 1; k <= 166; k++) begin
      @(negedge clk);
      if (fullnote == 10'd9) n9++;
      if (k <= 164 && playing && fullnote == 10'd0) gapc++;
      if (note_start) begin
        ns_cnt++;
        if (ns_cnt == 1) ns1 = k;
        if (ns_cnt == 2) ns2 = k;
      end
    end
    checks++;
    if (n9 !== 158) begin
      errors++;
      $display("FAIL long_play: got %0d expected 158", n9);
    end
    checks++;
    if (gapc !== 2) begin
      errors++;
      $display("FAIL long_gap: got %0d expected 2", gapc);
    end
    checks++;
    if (ns1 !== 3 || ns2 !== 165) begin
      errors++;
      $display("FAIL long_period: got starts at %0d and %0d expected 3 and 165", ns1, ns2);
    end
  endtask

  initial begin
    test_reset();
    test_song1();
    test_pause();
    test_song_change();
    test_wrap();
    test_reset_gap();
    test_long();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
